// File: rtl/pixel_coord_gen_if.sv
// Video timing in, pixel coordinates and frame geometry out.
// master is the coordinate generator, slave is the consumer side.
interface pixel_coord_gen_if;
    logic        vs_in;
    logic        de_in;
    logic [10:0] gr_x;
    logic [9:0]  gr_y;
    logic        en;
    logic        frame_start;
    logic [9:0]  lines_last;
    logic [10:0] pix_last;
    logic        locked;

    modport master (
        input  vs_in,
        input  de_in,
        output gr_x,
        output gr_y,
        output en,
        output frame_start,
        output lines_last,
        output pix_last,
        output locked
    );

    modport slave (
        output vs_in,
        output de_in,
        input  gr_x,
        input  gr_y,
        input  en,
        input  frame_start,
        input  lines_last,
        input  pix_last,
        input  locked
    );
endinterface

// File: rtl/pixel_coord_gen.sv
// Per-pixel x/y coordinate generator from vsync and data-enable,
// with per-frame line/pixel geometry capture and lock detection.
module pixel_coord_gen #(
    parameter bit          VS_POL = 1'b1,
    parameter logic [10:0] X_MAX  = 11'd2047,
    parameter logic [9:0]  Y_MAX  = 10'd1023
) (
    input  logic               clk,
    input  logic               reset,
    pixel_coord_gen_if.master  vid
);

    typedef enum logic {
        SEEK,
        FRAME
    } state_t;

    state_t      state;
    logic        vs_r;
    logic        vs_r2;
    logic        de_r;
    logic        de_r2;
    logic        have_prev;
    logic [10:0] line_len;

    logic        vs_edge;
    logic        de_rise;
    logic        de_fall;
    logic [10:0] x_inc;
    logic [9:0]  y_inc;
    logic [10:0] len_next;

    assign vs_edge  = (vs_r == VS_POL) && (vs_r2 != VS_POL);
    assign de_rise  = de_r && !de_r2;
    assign de_fall  = !de_r && de_r2;
    assign x_inc    = (vid.gr_x == X_MAX) ? X_MAX : vid.gr_x + 11'd1;
    assign y_inc    = (vid.gr_y == Y_MAX) ? Y_MAX : vid.gr_y + 10'd1;
    assign len_next = x_inc;

    // Sync registers reset to the active level so a vsync held active
    // through reset needs a full inactive-to-active transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SEEK;
            vs_r            <= VS_POL;
            vs_r2           <= VS_POL;
            de_r            <= 1'b0;
            de_r2           <= 1'b0;
            have_prev       <= 1'b0;
            line_len        <= '0;
            vid.gr_x        <= '0;
            vid.gr_y        <= '0;
            vid.en          <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.lines_last  <= '0;
            vid.pix_last    <= '0;
            vid.locked      <= 1'b0;
        end else begin
            vs_r            <= vid.vs_in;
            vs_r2           <= vs_r;
            de_r            <= vid.de_in;
            de_r2           <= de_r;
            vid.frame_start <= vs_edge;
            if (vs_edge) begin
                state    <= FRAME;
                vid.gr_x <= '0;
                vid.gr_y <= '0;
                vid.en   <= de_r;
                if (state == FRAME) begin
                    vid.lines_last <= vid.gr_y;
                    vid.pix_last   <= line_len;
                    vid.locked     <= have_prev
                                   && (vid.gr_y == vid.lines_last)
                                   && (vid.gr_y != '0);
                    have_prev      <= 1'b1;
                end
            end else if (state == FRAME) begin
                vid.en <= de_r;
                if (de_rise) begin
                    vid.gr_x <= '0;
                end else if (de_r) begin
                    vid.gr_x <= x_inc;
                end
                if (de_fall) begin
                    vid.gr_y <= y_inc;
                    line_len <= len_next;
                end
            end else begin
                vid.en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Bench for pixel_coord_gen: hand vectors on an active-low vsync
// instance, reference-model checking on the default instance.
module tb_pixel_coord_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    pixel_coord_gen_if a ();
    pixel_coord_gen_if b ();

    pixel_coord_gen dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vid   (a)
    );

    pixel_coord_gen #(.VS_POL(1'b0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vid   (b)
    );

    typedef struct {
        bit fs;
        bit en;
        bit lk;
        int x;
        int y;
        int ll;
        int pl;
    } out_t;

    typedef struct {
        bit vs;
        bit de;
        int x;
        int y;
        bit en;
        bit fs;
        int ll;
        int pl;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    out_t expq[$];
    bit   m_seek, m_pvs, m_pde, m_lk, m_have;
    int   m_x, m_y, m_len, m_ll, m_pl;

    int max_x, max_y;
    bit en_seen;

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    // One input sample; its outputs become visible two cycles later.
    function automatic void model_step(bit vs, bit de);
        out_t o;
        bit lead;
        lead = vs && !m_pvs;
        o.fs = 0;
        o.en = 0;
        if (lead) begin
            if (!m_seek) begin
                m_lk = m_have && (m_y == m_ll) && (m_y != 0);
                m_ll = m_y;
                m_pl = m_len;
                m_have = 1;
            end
            m_seek = 0;
            m_x = 0;
            m_y = 0;
            o.fs = 1;
            o.en = de;
        end else if (!m_seek) begin
            if (de && !m_pde) m_x = 0;
            else if (de) m_x = sat(m_x + 1, 2047);
            if (!de && m_pde) begin
                m_len = sat(m_x + 1, 2047);
                m_y = sat(m_y + 1, 1023);
            end
            o.en = de;
        end
        o.x = m_x;
        o.y = m_y;
        o.ll = m_ll;
        o.pl = m_pl;
        o.lk = m_lk;
        m_pvs = vs;
        m_pde = de;
        expq.push_back(o);
    endfunction

    function automatic void model_reset();
        expq.delete();
        m_seek = 1;
        m_pvs = 1;
        m_pde = 0;
        m_lk = 0;
        m_have = 0;
        m_x = 0;
        m_y = 0;
        m_len = 0;
        m_ll = 0;
        m_pl = 0;
        model_step(a.vs_in, a.de_in);
    endfunction

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".gr_x"}, int'(a.gr_x), 0);
        chk({nm, ".gr_y"}, int'(a.gr_y), 0);
        chk({nm, ".en"}, int'(a.en), 0);
        chk({nm, ".frame_start"}, int'(a.frame_start), 0);
        chk({nm, ".lines_last"}, int'(a.lines_last), 0);
        chk({nm, ".pix_last"}, int'(a.pix_last), 0);
        chk({nm, ".locked"}, int'(a.locked), 0);
    endtask

    task automatic check_out(out_t e);
        bit ok;
        ok = (int'(a.gr_x) == e.x) && (int'(a.gr_y) == e.y)
          && (a.en == e.en) && (a.frame_start == e.fs)
          && (int'(a.lines_last) == e.ll)
          && (int'(a.pix_last) == e.pl) && (a.locked == e.lk);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL model cyc=%0d got x=%0d y=%0d en=%0b fs=%0b ll=%0d pl=%0d lk=%0b want x=%0d y=%0d en=%0b fs=%0b ll=%0d pl=%0d lk=%0b",
                     cyc, a.gr_x, a.gr_y, a.en, a.frame_start,
                     a.lines_last, a.pix_last, a.locked,
                     e.x, e.y, e.en, e.fs, e.ll, e.pl, e.lk);
        end
    endtask

    task automatic step(bit vs, bit de);
        out_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (expq.size() == 2) begin
            e = expq.pop_front();
            check_out(e);
        end
        if (a.en) begin
            en_seen = 1;
            if (int'(a.gr_x) > max_x) max_x = int'(a.gr_x);
            if (int'(a.gr_y) > max_y) max_y = int'(a.gr_y);
        end
        a.vs_in = vs;
        a.de_in = de;
        model_step(vs, de);
    endtask

    task automatic vsync();
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic lines(int n, int ppl);
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < ppl; p++) step(1'b0, 1'b1);
            repeat (4) step(1'b0, 1'b0);
        end
    endtask

    vec_t tbl[13];

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a.vs_in = 1'b0;
        a.de_in = 1'b0;
        b.vs_in = 1'b1;
        b.de_in = 1'b0;
        max_x = 0;
        max_y = 0;
        en_seen = 0;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 2, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 2, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 2, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 2, 1};

        repeat (2) @(posedge clk);
        #3;
        chk_zero("reset");
        rst_b = 1'b0;

        for (int j = 0; j < 13; j++) begin
            bit ok;
            @(posedge clk);
            #1;
            ok = (int'(b.gr_x) == tbl[j].x) && (int'(b.gr_y) == tbl[j].y)
              && (b.en == tbl[j].en) && (b.frame_start == tbl[j].fs)
              && (int'(b.lines_last) == tbl[j].ll)
              && (int'(b.pix_last) == tbl[j].pl) && (b.locked == 1'b0);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL pol0 row=%0d got x=%0d y=%0d en=%0b fs=%0b ll=%0d pl=%0d lk=%0b want x=%0d y=%0d en=%0b fs=%0b ll=%0d pl=%0d lk=0",
                         j, b.gr_x, b.gr_y, b.en, b.frame_start,
                         b.lines_last, b.pix_last, b.locked,
                         tbl[j].x, tbl[j].y, tbl[j].en, tbl[j].fs,
                         tbl[j].ll, tbl[j].pl);
            end
            b.vs_in = tbl[j].vs;
            b.de_in = tbl[j].de;
        end

        #2;
        rst_a = 1'b0;
        model_reset();

        en_seen = 0;
        lines(3, 20);
        chk("seek_en", int'(en_seen), 0);
        chk_zero("seek");

        vsync();
        lines(48, 64);
        vsync();
        lines(48, 64);
        chk("f2_lines_last", int'(a.lines_last), 48);
        chk("f2_pix_last", int'(a.pix_last), 64);
        chk("f2_locked", int'(a.locked), 0);
        max_x = 0;
        max_y = 0;
        vsync();
        chk("f3_locked", int'(a.locked), 1);
        lines(48, 64);
        vsync();
        lines(48, 64);
        chk("span_x", max_x, 63);
        chk("span_y", max_y, 47);

        vsync();
        max_x = 0;
        lines(3, 640);
        chk("span_x640", max_x, 639);

        vsync();
        lines(1, 2100);
        chk("sat_x", max_x, 2047);
        vsync();
        chk("sat_pix_last", int'(a.pix_last), 2047);
        max_y = 0;
        lines(1100, 2);
        chk("sat_y", max_y, 1023);
        vsync();
        chk("sat_lines_last", int'(a.lines_last), 1023);

        lines(480, 2);
        vsync();
        lines(480, 2);
        vsync();
        chk("lock_480", int'(a.locked), 1);
        lines(479, 2);
        vsync();
        chk("lock_drop", int'(a.locked), 0);
        chk("lock_drop_ll", int'(a.lines_last), 479);
        lines(479, 2);
        vsync();
        chk("relock1", int'(a.locked), 1);
        lines(479, 2);
        vsync();
        chk("relock2", int'(a.locked), 1);

        lines(200, 2);
        chk("pre_reset_y", int'(a.gr_y), 200);
        step(1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(posedge clk);
        #3;
        rst_a = 1'b0;
        model_reset();
        en_seen = 0;
        lines(5, 10);
        chk("post_reset_seek_en", int'(en_seen), 0);
        vsync();
        lines(2, 10);
        chk("post_reset_en", int'(en_seen), 1);

        for (int f = 0; f < 40; f++) begin
            int w;
            int nl;
            int ppl;
            int bl;
            bit hold;
            w = $urandom_range(1, 4);
            hold = ($urandom_range(0, 7) == 0);
            nl = $urandom_range(3, 5);
            for (int i = 0; i < w; i++)
                step(1'b1, $urandom_range(0, 3) == 0);
            for (int l = 0; l < nl; l++) begin
                ppl = $urandom_range(1, 30);
                bl = $urandom_range(0, 3);
                for (int p = 0; p < ppl; p++) begin
                    if ($urandom_range(0, 63) == 0) step(1'b1, 1'b1);
                    else step(hold, 1'b1);
                end
                for (int q = 0; q < bl; q++) step(hold, 1'b0);
            end
        end
        repeat (4) step(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
